// File: rtl/point_double_ctrl.sv
// Affine point-doubling sequencer: (x3,y3) = 2*(x1,y1) over GF(P), driving one
// shared modular multiplier and one modular inverter; add/sub are done locally.
module point_double_ctrl #(
  parameter int unsigned  W = 256,
  parameter logic [W-1:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] y1,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] x3,
  output logic [W-1:0] y3,
  output logic         inf,
  output logic         err,
  output logic         mul_start,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  input  logic         mul_done,
  input  logic [W-1:0] mul_p,
  output logic         inv_start,
  output logic [W-1:0] inv_a,
  input  logic         inv_done,
  input  logic [W-1:0] inv_r
);

  typedef enum logic [3:0] {
    IDLE, SQ, A1, A2, A3, INV, LAM, LSQ, A4, S1, S2, YM, S3, FIN
  } state_e;

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    else                s = s;
    return s[W-1:0];
  endfunction

  // Wraps through 2^(W+1) on borrow; adding P lands back in [0,P).
  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[W]) d = d + {1'b0, P};
    else      d = d;
    return d[W-1:0];
  endfunction

  state_e       state_q, state_d;
  logic [W-1:0] x1_q, x1_d, y1_q, y1_d;
  logic [W-1:0] t0_q, t0_d, t1_q, t1_d, lam_q, lam_d;
  logic [W-1:0] x3_q, x3_d, y3_q, y3_d;
  logic [W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, inv_a_q, inv_a_d;
  logic         busy_q, busy_d, done_q, done_d, inf_q, inf_d, err_q, err_d;
  logic         mul_start_q, mul_start_d, inv_start_q, inv_start_d;
  logic         mul_ack_s, inv_ack_s;

  // A done pulse coinciding with our own start pulse cannot belong to this request.
  assign mul_ack_s = mul_done && !mul_start_q;
  assign inv_ack_s = inv_done && !inv_start_q;

  // Next-state and datapath: t0 holds t0/t3/t4/t7, t1 holds t1/t5/t6 in turn.
  always_comb begin
    state_d     = state_q;
    x1_d        = x1_q;
    y1_d        = y1_q;
    t0_d        = t0_q;
    t1_d        = t1_q;
    lam_d       = lam_q;
    x3_d        = x3_q;
    y3_d        = y3_q;
    inf_d       = inf_q;
    err_d       = err_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    inv_start_d = 1'b0;
    inv_a_d     = inv_a_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x1_d  = x1;
          y1_d  = y1;
          inf_d = 1'b0;
          err_d = 1'b0;
          if ((x1 >= P) || (y1 >= P)) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else if (y1 == '0) begin
            inf_d   = 1'b1;
            x3_d    = '0;
            y3_d    = '0;
            state_d = FIN;
          end else begin
            mul_start_d = 1'b1;
            mul_a_d     = x1;
            mul_b_d     = x1;
            state_d     = SQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SQ: begin
        if (mul_ack_s) begin
          t0_d    = mul_p;
          state_d = A1;
        end else begin
          state_d = SQ;
        end
      end
      A1: begin
        t1_d    = mod_add(t0_q, t0_q);
        state_d = A2;
      end
      A2: begin
        t1_d    = mod_add(t1_q, t0_q);
        state_d = A3;
      end
      A3: begin
        inv_a_d     = mod_add(y1_q, y1_q);
        inv_start_d = 1'b1;
        state_d     = INV;
      end
      INV: begin
        if (inv_ack_s) begin
          t0_d        = inv_r;
          mul_start_d = 1'b1;
          mul_a_d     = t1_q;
          mul_b_d     = inv_r;
          state_d     = LAM;
        end else begin
          state_d = INV;
        end
      end
      LAM: begin
        if (mul_ack_s) begin
          lam_d       = mul_p;
          mul_start_d = 1'b1;
          mul_a_d     = mul_p;
          mul_b_d     = mul_p;
          state_d     = LSQ;
        end else begin
          state_d = LAM;
        end
      end
      LSQ: begin
        if (mul_ack_s) begin
          t0_d    = mul_p;
          state_d = A4;
        end else begin
          state_d = LSQ;
        end
      end
      A4: begin
        t1_d    = mod_add(x1_q, x1_q);
        state_d = S1;
      end
      S1: begin
        x3_d    = mod_sub(t0_q, t1_q);
        state_d = S2;
      end
      S2: begin
        t1_d        = mod_sub(x1_q, x3_q);
        mul_start_d = 1'b1;
        mul_a_d     = lam_q;
        mul_b_d     = t1_d;
        state_d     = YM;
      end
      YM: begin
        if (mul_ack_s) begin
          t0_d    = mul_p;
          state_d = S3;
        end else begin
          state_d = YM;
        end
      end
      S3: begin
        y3_d    = mod_sub(t0_q, y1_q);
        state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == FIN);
    busy_d = (state_d != IDLE) && (state_d != FIN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x1_q        <= '0;
      y1_q        <= '0;
      t0_q        <= '0;
      t1_q        <= '0;
      lam_q       <= '0;
      x3_q        <= '0;
      y3_q        <= '0;
      inf_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      inv_start_q <= 1'b0;
      inv_a_q     <= '0;
    end else begin
      state_q     <= state_d;
      x1_q        <= x1_d;
      y1_q        <= y1_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      lam_q       <= lam_d;
      x3_q        <= x3_d;
      y3_q        <= y3_d;
      inf_q       <= inf_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      inv_start_q <= inv_start_d;
      inv_a_q     <= inv_a_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign x3        = x3_q;
  assign y3        = y3_q;
  assign inf       = inf_q;
  assign err       = err_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign inv_start = inv_start_q;
  assign inv_a     = inv_a_q;

endmodule

// File: tb/tb_point_double_ctrl.sv
// Scoreboard bench for point_double_ctrl: secp256k1 instance plus a W=8/P=17 instance,
// each served by behavioural multiplier/inverter models with programmable latency.
module tb_point_double_ctrl;

  localparam logic [255:0] PA  = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam logic [255:0] GX  = 256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
  localparam logic [255:0] GY  = 256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
  localparam logic [255:0] G2X = 256'hC6047F94_41ED7D6D_3045406E_95C07CD8_5C778E4B_8CEF3CA7_ABAC09B9_5C709EE5;
  localparam logic [255:0] G2Y = 256'h1AE168FE_A63DC339_A3C58419_466CEAEE_F7F63265_3266D0E1_236431A9_50CFE52A;
  localparam logic [255:0] PB  = 256'd17;

  typedef struct {
    logic [255:0] x3;
    logic [255:0] y3;
    logic         inf;
    logic         err;
    int           dcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic         start_a = 1'b0, busy_a, done_a, inf_a, err_a, ms_a, is_a;
  logic         md_a = 1'b0, id_a = 1'b0;
  logic [255:0] x1_a = '0, y1_a = '0, x3_a, y3_a, ma_a, mb_a, ia_a;
  logic [255:0] mp_a = '0, ir_a = '0;

  logic         start_b = 1'b0, busy_b, done_b, inf_b, err_b, ms_b, is_b;
  logic         md_b = 1'b0, id_b = 1'b0;
  logic [7:0]   x1_b = '0, y1_b = '0, x3_b, y3_b, ma_b, mb_b, ia_b;
  logic [7:0]   mp_b = '0, ir_b = '0;

  exp_t q_a[$];
  exp_t q_b[$];
  int   lm_a = 1, li_a = 1, lm_b = 3, li_b = 1;
  int   mcnt_a = 0, icnt_a = 0, mcnt_b = 0, icnt_b = 0;
  int   nmul_a = 0, ninv_a = 0, nmul_b = 0, ninv_b = 0;
  int   inj_cyc_a = -1;
  logic [7:0] mula_log_b[$];
  logic [7:0] inva_seen_b = '0;

  point_double_ctrl u_a (
    .clk(clk), .rst(rst), .start(start_a), .x1(x1_a), .y1(y1_a),
    .busy(busy_a), .done(done_a), .x3(x3_a), .y3(y3_a), .inf(inf_a), .err(err_a),
    .mul_start(ms_a), .mul_a(ma_a), .mul_b(mb_a), .mul_done(md_a), .mul_p(mp_a),
    .inv_start(is_a), .inv_a(ia_a), .inv_done(id_a), .inv_r(ir_a)
  );

  point_double_ctrl #(.W(8), .P(8'd17)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .x1(x1_b), .y1(y1_b),
    .busy(busy_b), .done(done_b), .x3(x3_b), .y3(y3_b), .inf(inf_b), .err(err_b),
    .mul_start(ms_b), .mul_a(ma_b), .mul_b(mb_b), .mul_done(md_b), .mul_p(mp_b),
    .inv_start(is_b), .inv_a(ia_b), .inv_done(id_b), .inv_r(ir_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [255:0] mod_mul(input logic [255:0] a, input logic [255:0] b,
                                           input logic [255:0] p);
    logic [511:0] t;
    t = ({256'd0, a} * {256'd0, b}) % {256'd0, p};
    return t[255:0];
  endfunction

  function automatic logic [255:0] mod_inv(input logic [255:0] a, input logic [255:0] p);
    logic [255:0] r, base, e;
    r = 256'd1;
    base = a;
    e = p - 256'd2;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mod_mul(r, base, p);
      base = mod_mul(base, base, p);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic issue_a(input logic [255:0] x, input logic [255:0] y, input logic [255:0] ex,
                         input logic [255:0] ey, input logic einf, input logic eerr, input int lat);
    exp_t e;
    @(negedge clk);
    start_a = 1'b1; x1_a = x; y1_a = y;
    e.x3 = ex; e.y3 = ey; e.inf = einf; e.err = eerr; e.dcyc = cyc + lat;
    q_a.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_q(input bit is_b_side, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((is_b_side ? q_b.size() : q_a.size()) == 0) break;
      @(negedge clk);
    end
    if ((is_b_side ? q_b.size() : q_a.size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout side=%0d pending=%0d expected=0", is_b_side,
               is_b_side ? q_b.size() : q_a.size());
      if (is_b_side) q_b.delete(); else q_a.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Unit models and scoreboard monitor, evaluated away from the active edge.
  task automatic models_and_monitor();
    exp_t e;
    md_a = 1'b0; id_a = 1'b0; md_b = 1'b0; id_b = 1'b0;
    if (mcnt_a > 0) begin
      mcnt_a--;
      if (mcnt_a == 0) begin md_a = 1'b1; mp_a = mod_mul(ma_a, mb_a, PA); end
    end
    if (icnt_a > 0) begin
      icnt_a--;
      if (icnt_a == 0) begin id_a = 1'b1; ir_a = mod_inv(ia_a, PA); end
    end
    if (cyc == inj_cyc_a) begin md_a = 1'b1; mp_a = 256'h0BAD; end
    if (ms_a || is_a) begin
      checks++;
      if ((ms_a && is_a) || mcnt_a != 0 || icnt_a != 0) begin
        errors++;
        $display("FAIL a_req_overlap ms=%b is=%b mpend=%0d ipend=%0d expected single idle request",
                 ms_a, is_a, mcnt_a, icnt_a);
      end
      if (ms_a) begin mcnt_a = lm_a; nmul_a++; end
      if (is_a) begin icnt_a = li_a; ninv_a++; end
    end
    if (mcnt_b > 0) begin
      mcnt_b--;
      if (mcnt_b == 0) begin
        md_b = 1'b1;
        mp_b = 8'(mod_mul({248'd0, ma_b}, {248'd0, mb_b}, PB));
      end
    end
    if (icnt_b > 0) begin
      icnt_b--;
      if (icnt_b == 0) begin id_b = 1'b1; ir_b = 8'(mod_inv({248'd0, ia_b}, PB)); end
    end
    if (ms_b) begin mcnt_b = lm_b; nmul_b++; mula_log_b.push_back(ma_b); end
    if (is_b) begin icnt_b = li_b; ninv_b++; inva_seen_b = ia_b; end
    if (done_a) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_done at cyc=%0d expected no done", cyc);
      end else begin
        e = q_a.pop_front();
        if (x3_a !== e.x3 || y3_a !== e.y3 || inf_a !== e.inf || err_a !== e.err || cyc != e.dcyc) begin
          errors++;
          $display("FAIL a_result got x3=%h y3=%h inf=%b err=%b cyc=%0d expected x3=%h y3=%h inf=%b err=%b cyc=%0d",
                   x3_a, y3_a, inf_a, err_a, cyc, e.x3, e.y3, e.inf, e.err, e.dcyc);
        end
      end
    end
    if (done_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_done at cyc=%0d expected no done", cyc);
      end else begin
        e = q_b.pop_front();
        if ({248'd0, x3_b} !== e.x3 || {248'd0, y3_b} !== e.y3 || inf_b !== e.inf ||
            err_b !== e.err || cyc != e.dcyc) begin
          errors++;
          $display("FAIL b_result got x3=%0d y3=%0d inf=%b err=%b cyc=%0d expected x3=%0d y3=%0d inf=%b err=%b cyc=%0d",
                   x3_b, y3_b, inf_b, err_b, cyc, e.x3, e.y3, e.inf, e.err, e.dcyc);
        end
      end
    end
  endtask

  initial begin
    exp_t eb;
    int   n0, k0;
    fork
      forever begin
        @(negedge clk);
        models_and_monitor();
      end
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_a_ctrl", {248'd0, busy_a, done_a, inf_a, err_a, ms_a, is_a, 2'b00}, 256'd0);
    chk("reset_a_data", x3_a | y3_a | ma_a | mb_a | ia_a, 256'd0);
    chk("reset_b_all", {busy_b, done_b, inf_b, err_b, ms_b, is_b, x3_b, y3_b, ma_b, mb_b, ia_b}, 256'd0);

    // Point at infinity: early exit, no unit requests.
    n0 = nmul_a + ninv_a;
    issue_a(256'd5, 256'd0, 256'd0, 256'd0, 1'b1, 1'b0, 1);
    wait_q(1'b0, 10);
    chk("inf_no_unit_req", 256'(nmul_a + ninv_a - n0), 256'd0);

    // Generator doubling, Lm = Li = 1.
    issue_a(GX, GY, G2X, G2Y, 1'b0, 1'b0, 18);
    wait_q(1'b0, 40);

    // Unreduced input: err, result registers keep 2G.
    n0 = nmul_a + ninv_a;
    issue_a(PA, GY, G2X, G2Y, 1'b0, 1'b1, 1);
    wait_q(1'b0, 10);
    chk("err_no_unit_req", 256'(nmul_a + ninv_a - n0), 256'd0);

    // Start re-pulsed at cycles 3 and 10, spurious mul_done in A1 (cycle 3).
    issue_a(GX, GY, G2X, G2Y, 1'b0, 1'b0, 18);
    inj_cyc_a = cyc + 2;
    chk("busy_cycle1", {255'd0, busy_a}, 256'd1);
    @(negedge clk);
    @(negedge clk);
    start_a = 1'b1; x1_a = 256'd1; y1_a = 256'd1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    start_a = 1'b1; x1_a = 256'd7; y1_a = 256'd9;
    @(negedge clk);
    start_a = 1'b0;
    wait_q(1'b0, 40);
    inj_cyc_a = -1;

    // Reset two cycles into the LAM multiply; its late mul_done must be ignored.
    lm_a = 6;
    n0 = nmul_a;
    @(negedge clk);
    start_a = 1'b1; x1_a = GX; y1_a = GY;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (nmul_a >= n0 + 2) break;
      @(negedge clk);
    end
    chk("lam_mul_started", 256'(nmul_a - n0), 256'd2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ctrl", {248'd0, busy_a, done_a, inf_a, err_a, ms_a, is_a, 2'b00}, 256'd0);
    chk("abort_data", x3_a | y3_a | ma_a | mb_a | ia_a, 256'd0);
    repeat (10) @(negedge clk);
    chk("abort_idle_busy", {255'd0, busy_a}, 256'd0);
    lm_a = 1;
    issue_a(GX, GY, G2X, G2Y, 1'b0, 1'b0, 18);
    wait_q(1'b0, 40);

    // Small field: P=17, Lm=3, Li=1, (2,3) doubles to (0,1) via lambda=2.
    lm_b = 3;
    n0 = nmul_b;
    k0 = ninv_b;
    mula_log_b.delete();
    @(negedge clk);
    start_b = 1'b1; x1_b = 8'd2; y1_b = 8'd3;
    eb.x3 = 256'd0; eb.y3 = 256'd1; eb.inf = 1'b0; eb.err = 1'b0; eb.dcyc = cyc + 26;
    q_b.push_back(eb);
    @(negedge clk);
    start_b = 1'b0;
    wait_q(1'b1, 60);
    chk("b_mul_count", 256'(nmul_b - n0), 256'd4);
    chk("b_inv_count", 256'(ninv_b - k0), 256'd1);
    chk("b_inv_operand", {248'd0, inva_seen_b}, 256'd6);
    if (mula_log_b.size() >= 3) begin
      chk("b_lambda", {248'd0, mula_log_b[2]}, 256'd2);
    end else begin
      checks++;
      errors++;
      $display("FAIL b_lambda mul_log_size=%0d expected>=3", mula_log_b.size());
    end

    chk("a_queue_drained", 256'(q_a.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/point_double_ctrl.md
Name: point_double_ctrl

Overview:
- Sequencer for affine secp256k1 point doubling: (x3,y3) = 2·(x1,y1), with λ = 3·x1² / (2·y1) mod P.
- Time-shares one external multi-cycle modular multiplier and one external modular inverter.
- Performs modular add/sub internally.
- Sits between the scalar-multiply control layer and the shared field-arithmetic units.

Parameters:
W, 256, field element width
P, 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F, field prime

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only in IDLE
x1  in  W  input x, latched when start accepted
y1  in  W  input y, latched when start accepted
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
x3  out  W  result x, held until next accepted start
y3  out  W  result y, held until next accepted start
inf  out  1  result is the point at infinity (y1==0); valid with done
err  out  1  input not reduced (x1≥P or y1≥P); valid with done
mul_start  out  1  one-cycle pulse to multiplier
mul_a  out  W  multiplier operand, stable from mul_start until mul_done
mul_b  out  W  multiplier operand, stable from mul_start until mul_done
mul_done  in  1  one-cycle pulse, ≥1 cycle after mul_start
mul_p  in  W  product a·b mod P, valid with mul_done
inv_start  out  1  one-cycle pulse to inverter
inv_a  out  W  inverter operand, stable until inv_done
inv_done  in  1  one-cycle pulse, ≥1 cycle after inv_start
inv_r  in  W  a⁻¹ mod P, valid with inv_done

Behaviour:
- Reset:
  - busy, done, inf, err, mul_start, inv_start = 0.
  - x3, y3, mul_a, mul_b, inv_a = 0.
  - State = IDLE. All internal temporaries are cleared.
- Reset mid-operation:
  - Abort and return to IDLE next cycle; no done pulse.
  - Any later mul_done/inv_done is ignored while in IDLE.
- Modular add: s = a+b computed at W+1 bits; subtract P if s ≥ P.
- Modular sub: a−b; add P on borrow. Operands are always < P.
- IDLE, start=1 (cycle 0):
  - Latch x1/y1 and clear inf/err.
  - If x1≥P or y1≥P: go to FIN with err=1; x3/y3 unchanged.
  - Else if y1==0: go to FIN with inf=1, x3=y3=0.
  - Else go to SQ.
  - start is ignored outside IDLE.
- Operation sequence (one state each, in this order):
  - SQ: t0 = x1·x1 (MUL)
  - A1: t1 = t0+t0 (ADD)
  - A2: t1 = t1+t0 (ADD)
  - A3: t2 = y1+y1 (ADD)
  - INV: t3 = t2⁻¹ (INV)
  - LAM: λ = t1·t3 (MUL)
  - LSQ: t4 = λ·λ (MUL)
  - A4: t5 = x1+x1 (ADD)
  - S1: x3 = t4−t5 (SUB)
  - S2: t6 = x1−x3 (SUB)
  - YM: t7 = λ·t6 (MUL)
  - S3: y3 = t7−y1 (SUB)
  - FIN
- ADD/SUB states: 1 cycle each.
- MUL/INV states:
  - mul_start/inv_start pulses in the first cycle of the state.
  - The state waits for done; the result is captured on the done cycle, and the next state begins the following cycle.
  - With unit latency L (done L cycles after start), the state lasts L+1 cycles.
  - A done pulse arriving in any other state is ignored.
- FIN: done=1 for one cycle, busy=0, then IDLE. A start in that FIN cycle is ignored.
- Latency with multiplier latency Lm and inverter latency Li: done is asserted 4(Lm+1)+(Li+1)+8 cycles after the start cycle.
- Early-exit latency (inf or err): done at cycle 1; no mul_start/inv_start ever issued.
- Only one of mul_start/inv_start is asserted at any cycle; never re-asserted while a request is outstanding.

Test Plan:
- Default params, Lm=Li=1, x1=79BE667E…16F81798, y1=483ADA77…FB10D4B8 (generator G) -> done at cycle 18, x3=C6047F94…5C709EE5, y3=1AE168FE…50CFE52A, inf=err=0.
- W=8, P=17, Lm=3, Li=1, x1=2, y1=3 -> exactly 4 mul_start, 1 inv_start (inv_a=6, inv_r=3 returned), λ=2, x3=0, y3=1; done at cycle 26.
- y1=0, x1=5 -> done at cycle 1, inf=1, x3=y3=0, no mul_start/inv_start.
- x1=P -> done at cycle 1, err=1, x3/y3 retain previous values.
- start re-pulsed at cycles 3 and 10 during an operation -> ignored; single done with the original result; spurious mul_done injected during A1 -> ignored.
- rst asserted 2 cycles after mul_start in LAM, released, then mul_done arrives -> no done pulse, busy=0, all outputs zero; a new G request afterwards completes correctly.
